// File: rtl/mux_nbit_x4_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_nbit_x4_rr_if
// Brief    : Four source channels plus one merged output stream, each with
//            a valid/ready handshake, shared by the merger and its neighbours.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_nbit_x4_rr_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] a;
  logic                 a_valid;
  logic                 a_ready;
  logic [BUS_WIDTH-1:0] b;
  logic                 b_valid;
  logic                 b_ready;
  logic [BUS_WIDTH-1:0] c;
  logic                 c_valid;
  logic                 c_ready;
  logic [BUS_WIDTH-1:0] d;
  logic                 d_valid;
  logic                 d_ready;
  logic [BUS_WIDTH-1:0] y;
  logic [1:0]           sel;
  logic                 y_valid;
  logic                 y_ready;

  // The merger side: consumes the four channels, produces y.
  modport slave (
    input  a, a_valid, b, b_valid, c, c_valid, d, d_valid, y_ready,
    output a_ready, b_ready, c_ready, d_ready, y, sel, y_valid
  );

  // The surrounding side: drives the channels, consumes y.
  modport master (
    output a, a_valid, b, b_valid, c, c_valid, d, d_valid, y_ready,
    input  a_ready, b_ready, c_ready, d_ready, y, sel, y_valid
  );
endinterface
`default_nettype wire

// File: rtl/mux_nbit_x4_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_nbit_x4_rr
// Brief    : 4-to-1 round-robin streaming merger with a registered,
//            source-tagged output beat.
// Revision : 1.0 - initial release
// ============================================================================
module mux_nbit_x4_rr #(
  parameter int BUS_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  mux_nbit_x4_rr_if.slave  bus
);

  localparam logic [1:0] c_last_rst = 2'd3;

  logic [BUS_WIDTH-1:0] r_y;
  logic [1:0]           r_sel;
  logic                 r_y_valid;
  logic [1:0]           r_last;

  logic [BUS_WIDTH-1:0] w_data [4];
  logic [3:0]           w_valid;
  logic                 w_free;
  logic                 w_grant;
  logic [1:0]           w_gidx;
  logic                 w_take;
  logic [3:0]           w_ready;

  always_comb begin
    w_data[0] = bus.a;
    w_data[1] = bus.b;
    w_data[2] = bus.c;
    w_data[3] = bus.d;
    w_valid   = {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid};
  end

  // The output slot can take a new beat when empty or draining this cycle.
  assign w_free = !r_y_valid || bus.y_ready;

  // Search starts one past the last winner and wraps 3->0.
  always_comb begin : arb
    logic [1:0] v_idx;
    w_grant = 1'b0;
    w_gidx  = 2'd0;
    v_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      v_idx = r_last + 2'(i + 1);
      if (!w_grant && w_valid[v_idx]) begin
        w_grant = 1'b1;
        w_gidx  = v_idx;
      end
    end
  end

  // Gating with reset_n keeps every ready low while reset is held.
  assign w_take  = w_free && w_grant && reset_n;
  assign w_ready = w_take ? (4'b0001 << w_gidx) : 4'b0000;

  assign bus.a_ready = w_ready[0];
  assign bus.b_ready = w_ready[1];
  assign bus.c_ready = w_ready[2];
  assign bus.d_ready = w_ready[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_y       <= '0;
      r_sel     <= 2'd0;
      r_y_valid <= 1'b0;
      r_last    <= c_last_rst;
    end else if (w_free) begin
      if (w_grant) begin
        r_y       <= w_data[w_gidx];
        r_sel     <= w_gidx;
        r_y_valid <= 1'b1;
        r_last    <= w_gidx;
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign bus.y       = r_y;
  assign bus.sel     = r_sel;
  assign bus.y_valid = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_nbit_x4_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_nbit_x4_rr
// Brief    : Directed and random stimulus for the round-robin merger with a
//            reference arbiter model and an output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_nbit_x4_rr;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mux_nbit_x4_rr_if #(.BUS_WIDTH(8)) bus ();

  mux_nbit_x4_rr #(.BUS_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int         total = 0;
  int         bad   = 0;
  logic [1:0] m_last;
  logic       m_yv;
  logic [9:0] sbq [$];
  logic [3:0] obs_rdy;
  logic [3:0] pending;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] da, input logic [7:0] db,
                       input logic [7:0] dc, input logic [7:0] dd, input logic yr);
    bus.a = da; bus.b = db; bus.c = dc; bus.d = dd;
    {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid} = v;
    bus.y_ready = yr;
  endtask

  task automatic model_reset();
    m_yv   = 1'b0;
    m_last = 2'd3;
    sbq.delete();
  endtask

  // One clock: compare against the model before the edge, then advance it.
  task automatic cycle();
    logic [3:0] v;
    logic [7:0] dv [4];
    logic       free;
    logic       g;
    logic [1:0] gi;
    logic [1:0] idx;
    logic [3:0] exp_rdy;
    #1;
    v     = {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid};
    dv[0] = bus.a; dv[1] = bus.b; dv[2] = bus.c; dv[3] = bus.d;
    free  = !m_yv || bus.y_ready;
    g     = 1'b0;
    gi    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = m_last + 2'(k + 1);
      if (!g && v[idx]) begin
        g  = 1'b1;
        gi = idx;
      end
    end
    exp_rdy = (free && g && reset_n) ? (4'b0001 << gi) : 4'b0000;
    obs_rdy = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
    check("ready", obs_rdy, exp_rdy);
    check("y_valid", bus.y_valid, m_yv);
    if (m_yv && sbq.size() > 0)
      check("y_sel", {bus.sel, bus.y}, sbq[0]);
    pending = v & ~obs_rdy;
    @(posedge clk);
    if (reset_n) begin
      if (m_yv && bus.y_ready && sbq.size() > 0)
        void'(sbq.pop_front());
      if (free) begin
        m_yv = g;
        if (g) begin
          sbq.push_back({gi, dv[gi]});
          m_last = gi;
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [7:0] rd [4];
    logic [3:0] rv;
    reset_n = 1'b0;
    model_reset();
    pending = 4'b0;
    drive(4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0);
    @(posedge clk); #1;
    check("rst_y_valid", bus.y_valid, 1'b0);
    check("rst_y", bus.y, 8'h00);
    check("rst_sel", bus.sel, 2'd0);
    drive(4'b1111, 8'h1, 8'h2, 8'h3, 8'h4, 1'b1);
    cycle();
    check("rst_ready_low", obs_rdy, 4'b0000);

    // Release with a and b competing: channel 0 wins first.
    #2 reset_n = 1'b1;
    drive(4'b0011, 8'h5A, 8'h6B, 8'h0, 8'h0, 1'b1);
    cycle();
    check("t1_first_grant", obs_rdy, 4'b0001);

    // Single beat on c.
    drive(4'b0100, 8'h0, 8'h0, 8'hA5, 8'h0, 1'b1);
    cycle();
    check("t2_c_ready", obs_rdy, 4'b0100);
    drive(4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b1);
    check("t2_y", {bus.sel, bus.y}, {2'd2, 8'hA5});
    check("t2_y_valid", bus.y_valid, 1'b1);
    cycle();
    check("t2_y_valid_drop", bus.y_valid, 1'b0);

    // Park the pointer on d so contention starts at channel 0.
    drive(4'b1000, 8'h0, 8'h0, 8'h0, 8'h77, 1'b1);
    cycle();
    check("t3_pre_d", obs_rdy, 4'b1000);

    // Full contention.
    drive(4'b1111, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("t3_seq", {bus.y_valid, bus.sel, bus.y}, {1'b1, 2'(k % 4), 8'((k % 4) + 1)});
    end

    // Backpressure with y=11 sel=1 held.
    drive(4'b0010, 8'h0, 8'h11, 8'h0, 8'h0, 1'b1);
    cycle();
    drive(4'b1111, 8'h21, 8'h11, 8'h23, 8'h24, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t4_ready_low", obs_rdy, 4'b0000);
      check("t4_hold", {bus.y_valid, bus.sel, bus.y}, {1'b1, 2'd1, 8'h11});
    end
    drive(4'b1111, 8'h21, 8'h11, 8'h23, 8'h24, 1'b1);
    cycle();
    check("t4_next_grant", obs_rdy, 4'b0100);

    // Grant d, idle, then a and d compete: pointer still 3.
    drive(4'b1000, 8'h0, 8'h0, 8'h0, 8'h3D, 1'b1);
    cycle();
    check("t5_grant_d", obs_rdy, 4'b1000);
    drive(4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b1);
    cycle();
    cycle();
    drive(4'b1001, 8'h3A, 8'h0, 8'h0, 8'h3E, 1'b1);
    cycle();
    check("t5_after_idle", obs_rdy, 4'b0001);

    // Mid-stream reset while y holds a beat.
    drive(4'b1111, 8'h41, 8'h42, 8'h43, 8'h44, 1'b0);
    check("t1_pre_valid", bus.y_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t1_async_valid", bus.y_valid, 1'b0);
    check("t1_async_y", bus.y, 8'h00);
    check("t1_async_sel", bus.sel, 2'd0);
    model_reset();
    cycle();
    check("t1_rst_ready", obs_rdy, 4'b0000);
    #2 reset_n = 1'b1;
    drive(4'b0011, 8'h51, 8'h52, 8'h0, 8'h0, 1'b1);
    cycle();
    check("t1_post_grant", obs_rdy, 4'b0001);

    // Random soak: data held stable while a beat is waiting.
    pending = 4'b0;
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pending[i]) rd[i] = 8'($urandom);
        rv[i] = ($urandom_range(0, 9) < 6);
      end
      drive(rv, rd[0], rd[1], rd[2], rd[3], 1'($urandom_range(0, 3) != 0));
      cycle();
    end
    drive(4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b1);
    cycle();
    cycle();
    check("drain_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
